raster_sweep_ctrl: RTL and testbench
====================================

// Module: raster_sweep_ctrl
// PURPOSE
//   Sequencer for a 2D raster sweep of a feature map: emits (col,row,addr) beats with valid/ready.
//   Column and row indices behave as increment-then-stop counters (start at 0, hold at the end value).
//   Address = base + row*pitch + col, computed by accumulation (no multiplier).
//   Sits between layer control (start/done) and a memory read port / window buffer (valid/ready).
// PARAMETERS
//   ColBits   5   width of column index; max columns = 2**ColBits
//   RowBits   5   width of row index; max rows = 2**RowBits
//   AddrBits  10  width of address, base and pitch
// PORTS
//   clk_i         in   1         clock, all logic on posedge
//   arst_ni       in   1         asynchronous active-low reset
//   start_i       in   1         begin sweep; sampled only in IDLE
//   abort_i       in   1         synchronous abort of a sweep, any state
//   last_col_i    in   ColBits   final column index (cols-1); latched at start
//   last_row_i    in   RowBits   final row index (rows-1); latched at start
//   base_addr_i   in   AddrBits  address of (0,0); latched at start
//   row_pitch_i   in   AddrBits  address step between rows; latched at start
//   valid_o       out  1         beat valid
//   ready_i       in   1         consumer accepts beat
//   col_o         out  ColBits   column index of current beat
//   row_o         out  RowBits   row index of current beat
//   addr_o        out  AddrBits  address of current beat
//   last_o        out  1         current beat is (last_col,last_row)
//   busy_o        out  1         high in RUN and DONE
//   done_o        out  1         one-cycle pulse after final beat accepted
// BEHAVIOUR
//   Reset (arst_ni=0, async): state=IDLE; valid_o, busy_o, done_o, last_o = 0.
//     col_o, row_o, addr_o = 0. All latched configuration = 0.
//   States: IDLE, RUN, DONE.
//   IDLE: start_i=1 latches config and sets col=0, row=0, addr=base, row_base=base; next state RUN.
//     Latency: start_i at edge n -> valid_o=1 after edge n, first beat visible in cycle n+1.
//   RUN: valid_o=1. A transfer is valid_o & ready_i at a posedge.
//     col<last_col : col+1, addr+1.
//     col==last_col, row<last_row : col=0, row+1, row_base+=pitch, addr=row_base+pitch.
//     col==last_col, row==last_row (last_o=1) : next state DONE; indices/addr hold.
//   DONE: valid_o=0, done_o=1 for exactly one cycle; next state IDLE.
//   Back-pressure: while valid_o & !ready_i, col_o/row_o/addr_o/last_o hold stable.
//   last_o = (col==last_col) & (row==last_row) & valid_o (combinational from registers).
//   Arithmetic: addr and row_base are modulo 2**AddrBits; wrap is silent, not flagged.
//     Indices never exceed the latched last values (stop semantics), so they never wrap.
//   Degenerate: last_col=0, last_row=0 -> single beat, last_o=1 on it.
//   start_i outside IDLE is ignored; config input changes mid-sweep have no effect.
//   abort_i=1 at a posedge from RUN/DONE -> IDLE next cycle, valid_o=0, no done_o pulse.
//     abort_i in IDLE is a no-op; abort_i with start_i in IDLE -> abort wins, stay IDLE.
//   DONE and start_i in the same cycle: start ignored; a new start is accepted from IDLE only.
//   Async reset mid-sweep: immediate return to reset values; no done_o pulse.
//   Sim-only assert (ENABLE_SIMULATION_ASSERTS): outputs stable under back-pressure;
//     done_o never high for 2 consecutive cycles.
// TESTING
//   1 Basic: last_col=2,last_row=1,base=0x010,pitch=0x020,ready=1 -> addrs 010,011,012,030,031,032;
//     last_o on 6th beat; done_o one cycle later; busy_o low next cycle.
//   2 Back-pressure: same config, ready toggled 1,0,0,1 per cycle -> 6 beats; each beat held while
//     ready=0; no beat duplicated or skipped.
//   3 Single beat: last_col=0,last_row=0,base=0x3FF -> one beat addr=3FF,last_o=1, then done_o.
//   4 Wrap: base=0x3FE,pitch=0x001,last_col=3,last_row=0 -> addrs 3FE,3FF,000,001.
//   5 Abort: abort_i on 3rd beat of test 1 -> valid_o=0 next cycle, no done_o; new start restarts
//     at (0,0).
//   6 Reset/start: arst_ni low mid-sweep -> outputs 0 immediately; start_i during RUN ignored;
//     start_i+abort_i in IDLE -> stays IDLE.

Source files
------------

// File: rtl/raster_sweep_ctrl_if.sv
// rtl/raster_sweep_ctrl_if.sv - control, configuration and beat stream of the raster sweep sequencer
interface raster_sweep_ctrl_if #(
  parameter int ColBits  = 5,
  parameter int RowBits  = 5,
  parameter int AddrBits = 10
);
  logic                start_i;
  logic                abort_i;
  logic [ColBits-1:0]  last_col_i;
  logic [RowBits-1:0]  last_row_i;
  logic [AddrBits-1:0] base_addr_i;
  logic [AddrBits-1:0] row_pitch_i;
  logic                valid_o;
  logic                ready_i;
  logic [ColBits-1:0]  col_o;
  logic [RowBits-1:0]  row_o;
  logic [AddrBits-1:0] addr_o;
  logic                last_o;
  logic                busy_o;
  logic                done_o;

  modport master (
    input  start_i, abort_i, last_col_i, last_row_i, base_addr_i, row_pitch_i, ready_i,
    output valid_o, col_o, row_o, addr_o, last_o, busy_o, done_o
  );

  modport slave (
    output start_i, abort_i, last_col_i, last_row_i, base_addr_i, row_pitch_i, ready_i,
    input  valid_o, col_o, row_o, addr_o, last_o, busy_o, done_o
  );
endinterface

// File: rtl/raster_sweep_ctrl.sv
// rtl/raster_sweep_ctrl.sv - 2D raster sweep sequencer emitting (col,row,addr) beats
module raster_sweep_ctrl #(
  parameter int ColBits  = 5,
  parameter int RowBits  = 5,
  parameter int AddrBits = 10
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  raster_sweep_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [ColBits-1:0]  col_q, last_col_q;
  logic [RowBits-1:0]  row_q, last_row_q;
  logic [AddrBits-1:0] addr_q, row_base_q, pitch_q;

  logic at_col_end, at_row_end, xfer, launch;

  assign at_col_end = (col_q == last_col_q);
  assign at_row_end = (row_q == last_row_q);
  assign xfer       = (state_q == RUN) & bus.ready_i & ~bus.abort_i;
  assign launch     = (state_q == IDLE) & bus.start_i & ~bus.abort_i;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (launch) state_d = RUN;
      RUN: begin
        if (bus.abort_i) state_d = IDLE;
        else if (xfer && at_col_end && at_row_end) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address advances by accumulation: +1 along a row, row_base+pitch at a row turn.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      last_col_q <= '0;
      last_row_q <= '0;
      pitch_q    <= '0;
    end else if (launch) begin
      last_col_q <= bus.last_col_i;
      last_row_q <= bus.last_row_i;
      pitch_q    <= bus.row_pitch_i;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= bus.base_addr_i;
      row_base_q <= bus.base_addr_i;
    end else if (xfer) begin
      if (!at_col_end) begin
        col_q  <= col_q + ColBits'(1);
        addr_q <= addr_q + AddrBits'(1);
      end else if (!at_row_end) begin
        col_q      <= '0;
        row_q      <= row_q + RowBits'(1);
        row_base_q <= row_base_q + pitch_q;
        addr_q     <= row_base_q + pitch_q;
      end
    end
  end

  assign bus.valid_o = (state_q == RUN);
  assign bus.busy_o  = (state_q == RUN) | (state_q == DONE);
  assign bus.done_o  = (state_q == DONE);
  assign bus.col_o   = col_q;
  assign bus.row_o   = row_q;
  assign bus.addr_o  = addr_q;
  assign bus.last_o  = at_col_end & at_row_end & bus.valid_o;

`ifdef ENABLE_SIMULATION_ASSERTS
  a_hold_stable : assert property (@(posedge clk_i) disable iff (!arst_ni)
    (bus.valid_o && !bus.ready_i && !bus.abort_i) |=>
      ($stable(col_q) && $stable(row_q) && $stable(addr_q) && $stable(bus.last_o)));
  a_done_pulse : assert property (@(posedge clk_i) disable iff (!arst_ni)
    bus.done_o |=> !bus.done_o);
`endif

endmodule

// File: tb/tb_raster_sweep_ctrl.sv
// tb/tb_raster_sweep_ctrl.sv - randomized self-checking bench for raster_sweep_ctrl
module tb_raster_sweep_ctrl;

  logic clk;
  logic arst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  raster_sweep_ctrl_if #(.ColBits(5), .RowBits(5), .AddrBits(10)) bus ();

  raster_sweep_ctrl #(.ColBits(5), .RowBits(5), .AddrBits(10)) dut (
    .clk_i   (clk),
    .arst_ni (arst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic scramble_cfg();
    bus.last_col_i  = 5'($urandom);
    bus.last_row_i  = 5'($urandom);
    bus.base_addr_i = 10'($urandom);
    bus.row_pitch_i = 10'($urandom);
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready
  task automatic run_sweep(input logic [4:0] lc, input logic [4:0] lr, input logic [9:0] base,
                           input logic [9:0] pitch, input int mode, input int abort_beat);
    int          exp_col[$];
    int          exp_row[$];
    int          exp_addr[$];
    int          n, idx, cyc;
    bit          fin, hold, r, ab;
    logic [4:0]  hc, hr;
    logic [9:0]  ha;
    for (int y = 0; y <= int'(lr); y++)
      for (int x = 0; x <= int'(lc); x++) begin
        exp_col.push_back(x);
        exp_row.push_back(y);
        exp_addr.push_back((int'(base) + y * int'(pitch) + x) % 1024);
      end
    n = exp_col.size();
    idx = 0; cyc = 0; fin = 0; hold = 0;
    hc = '0; hr = '0; ha = '0;

    @(negedge clk);
    bus.start_i = 1'b1;
    bus.last_col_i = lc; bus.last_row_i = lr; bus.base_addr_i = base; bus.row_pitch_i = pitch;
    @(negedge clk);
    bus.start_i = 1'b0;
    scramble_cfg();
    check_eq("busy_after_start", bus.busy_o, 1);

    while (!fin && cyc < 1000) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom);
      endcase
      bus.ready_i = r;
      bus.start_i = 1'($urandom);
      scramble_cfg();
      check_eq("valid_run", bus.valid_o, 1);
      if (hold) begin
        check_eq("hold_col", bus.col_o, hc);
        check_eq("hold_row", bus.row_o, hr);
        check_eq("hold_addr", bus.addr_o, ha);
      end
      ab = (idx == abort_beat);
      bus.abort_i = ab;
      if (!ab) begin
        check_eq("beat_col", bus.col_o, exp_col[idx]);
        check_eq("beat_row", bus.row_o, exp_row[idx]);
        check_eq("beat_addr", bus.addr_o, exp_addr[idx]);
        check_eq("beat_last", bus.last_o, (idx == n - 1));
        if (r) begin
          idx++;
          hold = 0;
        end else begin
          hold = 1;
          hc = bus.col_o; hr = bus.row_o; ha = bus.addr_o;
        end
      end
      @(negedge clk);
      bus.abort_i = 1'b0;
      bus.start_i = 1'b0;
      cyc++;
      if (ab) begin
        check_eq("abort_valid", bus.valid_o, 0);
        check_eq("abort_done", bus.done_o, 0);
        check_eq("abort_busy", bus.busy_o, 0);
        fin = 1;
      end else if (idx == n) begin
        check_eq("done_pulse", bus.done_o, 1);
        check_eq("done_valid", bus.valid_o, 0);
        check_eq("done_busy", bus.busy_o, 1);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        check_eq("done_one_cycle", bus.done_o, 0);
        check_eq("idle_busy", bus.busy_o, 0);
        check_eq("idle_valid", bus.valid_o, 0);
        @(negedge clk);
        check_eq("start_in_done_ignored", bus.busy_o, 0);
        fin = 1;
      end
    end
    check_eq("sweep_end", fin, 1);
    bus.ready_i = 1'b0;
  endtask

  task automatic reset_mid_sweep();
    @(negedge clk);
    bus.start_i = 1'b1; bus.ready_i = 1'b1;
    bus.last_col_i = 5'd3; bus.last_row_i = 5'd3; bus.base_addr_i = 10'h155; bus.row_pitch_i = 10'h010;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre_reset_busy", bus.busy_o, 1);
    arst_n = 1'b0;
    #1;
    check_eq("rst_valid", bus.valid_o, 0);
    check_eq("rst_busy", bus.busy_o, 0);
    check_eq("rst_done", bus.done_o, 0);
    check_eq("rst_last", bus.last_o, 0);
    check_eq("rst_pos", {bus.col_o, bus.row_o, bus.addr_o}, 0);
    @(negedge clk);
    arst_n = 1'b1;
    bus.ready_i = 1'b0;
    @(negedge clk);
    check_eq("post_rst_done", bus.done_o, 0);
  endtask

  initial begin
    arst_n = 1'b0;
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.ready_i = 1'b0;
    bus.last_col_i = '0; bus.last_row_i = '0; bus.base_addr_i = '0; bus.row_pitch_i = '0;
    #2;
    check_eq("reset_valid", bus.valid_o, 0);
    check_eq("reset_busy", bus.busy_o, 0);
    check_eq("reset_pos", {bus.col_o, bus.row_o, bus.addr_o, bus.last_o, bus.done_o}, 0);
    @(negedge clk);
    arst_n = 1'b1;

    run_sweep(5'd2, 5'd1, 10'h010, 10'h020, 0, -1);
    run_sweep(5'd2, 5'd1, 10'h010, 10'h020, 1, -1);
    run_sweep(5'd0, 5'd0, 10'h3FF, 10'h000, 0, -1);
    run_sweep(5'd3, 5'd0, 10'h3FE, 10'h001, 0, -1);
    run_sweep(5'd2, 5'd1, 10'h010, 10'h020, 0, 2);
    run_sweep(5'd2, 5'd1, 10'h010, 10'h020, 2, -1);

    @(negedge clk);
    bus.start_i = 1'b1; bus.abort_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    check_eq("start_abort_idle", bus.busy_o, 0);
    check_eq("start_abort_valid", bus.valid_o, 0);

    reset_mid_sweep();

    for (int t = 0; t < 8; t++)
      run_sweep(5'($urandom_range(0, 6)), 5'($urandom_range(0, 4)), 10'($urandom),
                10'($urandom), 2, (t % 3 == 2) ? int'($urandom_range(0, 3)) : -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
